// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared constants and state type for the ROM download loader
package rom_loader_pkg;

    localparam logic [7:0]  ROM_INDEX_DEFAULT = 8'h00;
    localparam logic [13:0] PROG_BASE         = 14'h0000;
    localparam logic [13:0] GFX_BASE          = 14'h2000;
    localparam logic [13:0] IMAGE_SIZE        = 14'h3000;
    localparam logic [13:0] CNT_MAX           = 14'h3FFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERROR
    } load_state_t;

endpackage

// File: rtl/rom_loader_if.sv
// rtl/rom_loader_if.sv - MiSTer ioctl download byte stream
interface rom_loader_if;

    logic        download;
    logic [7:0]  index;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;

    modport master (output download, index, wr, addr, dout);
    modport slave  (input  download, index, wr, addr, dout);

endinterface

// File: rtl/rom_region_decode.sv
// rtl/rom_region_decode.sv - maps a download byte offset onto the program or graphics ROM
module rom_region_decode
    import rom_loader_pkg::*;
#(
    parameter int PROG_AW = 13,
    parameter int GFX_AW  = 12
) (
    input  logic [24:0]        addr,
    output logic               prog_sel,
    output logic               gfx_sel,
    output logic               overflow,
    output logic [PROG_AW-1:0] local_addr
);

    logic [24:0] rel;

    // The graphics region starts on a 4 KB boundary, so its local address is just the low bits.
    always_comb begin
        rel        = addr - 25'(PROG_BASE);
        prog_sel   = rel < 25'(GFX_BASE);
        gfx_sel    = !prog_sel && (rel < 25'(IMAGE_SIZE));
        overflow   = !prog_sel && !gfx_sel;
        local_addr = prog_sel ? rel[PROG_AW-1:0] : PROG_AW'(rel[GFX_AW-1:0]);
    end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - turns the ioctl download into ROM write strobes and gates CPU reset on a complete image
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int         PROG_AW   = 13,
    parameter int         GFX_AW    = 12,
    parameter logic [7:0] ROM_INDEX = ROM_INDEX_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    rom_loader_if.slave        ioctl,
    output logic               prog_we,
    output logic [PROG_AW-1:0] prog_addr,
    output logic               gfx_we,
    output logic [GFX_AW-1:0]  gfx_addr,
    output logic [7:0]         wr_data,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err,
    output logic [7:0]         prog_sum
);

    load_state_t        state;
    logic               dl_q;
    logic               overflow;
    logic [13:0]        byte_cnt;

    logic               idx_match, dl_rise, dl_fall, start, accept, counted;
    logic               prog_sel, gfx_sel, over_sel;
    logic [PROG_AW-1:0] local_addr;
    logic [13:0]        cnt_base, cnt_next;
    logic [7:0]         sum_base, sum_next;
    logic               ovf_next;

    rom_region_decode #(
        .PROG_AW (PROG_AW),
        .GFX_AW  (GFX_AW)
    ) u_decode (
        .addr       (ioctl.addr),
        .prog_sel   (prog_sel),
        .gfx_sel    (gfx_sel),
        .overflow   (over_sel),
        .local_addr (local_addr)
    );

    // A strobe coincident with the falling edge still belongs to the download (dl_q is high).
    always_comb begin
        idx_match = ioctl.index == ROM_INDEX;
        dl_rise   = ioctl.download && !dl_q;
        dl_fall   = !ioctl.download && dl_q;
        start     = dl_rise && idx_match && (state != LOAD);
        accept    = ioctl.wr && idx_match &&
                    (start || ((state == LOAD) && (ioctl.download || dl_q)));
        counted   = accept && (prog_sel || gfx_sel);

        cnt_base  = start ? '0 : byte_cnt;
        sum_base  = start ? '0 : prog_sum;
        cnt_next  = (counted && (cnt_base != CNT_MAX)) ? cnt_base + 14'd1 : cnt_base;
        sum_next  = (accept && prog_sel) ? sum_base + ioctl.dout : sum_base;
        ovf_next  = (!start && overflow) || (accept && over_sel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dl_q      <= ioctl.download;
            overflow  <= 1'b0;
            byte_cnt  <= '0;
            prog_we   <= 1'b0;
            gfx_we    <= 1'b0;
            prog_addr <= '0;
            gfx_addr  <= '0;
            wr_data   <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            prog_sum  <= '0;
        end else begin
            dl_q     <= ioctl.download;
            prog_we  <= accept && prog_sel;
            gfx_we   <= accept && gfx_sel;
            byte_cnt <= cnt_next;
            overflow <= ovf_next;
            prog_sum <= sum_next;
            if (accept && prog_sel) prog_addr <= local_addr;
            if (accept && gfx_sel)  gfx_addr  <= local_addr[GFX_AW-1:0];
            if (counted)            wr_data   <= ioctl.dout;

            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state     <= LOAD;
                        cpu_hold  <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (dl_fall) begin
                        if ((cnt_next == IMAGE_SIZE) && !ovf_next) begin
                            state     <= DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Upstream stage of the 8 KB 6502 program ROM and the 4 KB graphics ROM: turns the MiSTer ioctl download byte stream into registered write strobes for both BRAM images.
- Holds the CPU in reset until a complete, correctly sized image has arrived.
- Computes an 8-bit additive checksum of the program image for the OSD/debug readout.

Parameters:
- PROG_AW, 13, program ROM address width (8192 bytes)
- GFX_AW, 12, graphics ROM address width (4096 bytes)
- ROM_INDEX, 8'h00, ioctl_index value identifying the ROM download

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  high for the duration of a download
- ioctl_index  in  8  download slot selector
- ioctl_wr  in  1  one-cycle byte-valid strobe
- ioctl_addr  in  25  byte offset within the download
- ioctl_dout  in  8  download byte
- prog_we  out  1  program ROM write enable
- prog_addr  out  PROG_AW  program ROM write address
- gfx_we  out  1  graphics ROM write enable
- gfx_addr  out  GFX_AW  graphics ROM write address
- wr_data  out  8  write data shared by both ROMs
- cpu_hold  out  1  CPU reset request
- load_done  out  1  valid image present
- load_err  out  1  last download short or overflowed
- prog_sum  out  8  sum mod 256 of program bytes

Behaviour:
- One clock domain. Reset is synchronous and active-high; clock and reset ports are clk and reset.
- Reset values:
  - prog_we = gfx_we = 0, addresses = 0, wr_data = 0
  - cpu_hold = 1, load_done = 0, load_err = 0, prog_sum = 0
  - state = IDLE, byte counter = 0
- A byte is accepted when ioctl_download = 1, ioctl_index = ROM_INDEX and ioctl_wr = 1. Strobes with any other index are ignored entirely.
- Address map, applied to ioctl_addr of each accepted byte:
  - 0x0000–0x1FFF: prog_we = 1 next cycle, prog_addr = ioctl_addr[12:0]; prog_sum += byte (mod 256).
  - 0x2000–0x2FFF: gfx_we = 1 next cycle, gfx_addr = ioctl_addr[11:0].
  - ≥ 0x3000: no write; sets the internal overflow flag.
- Latency: exactly one cycle from accepted ioctl_wr to the we pulse. The we pulse lasts one cycle. wr_data holds the registered byte. prog_we and gfx_we are never both high.
- Byte counter: 14 bits, saturating at 0x3FFF. It counts accepted bytes in the 0x0000–0x2FFF range only.
- States:
  - IDLE: rising edge of ioctl_download with matching index → LOAD. On entry: counter = 0, prog_sum = 0, overflow = 0, cpu_hold = 1, load_done = 0, load_err = 0.
  - LOAD: accept bytes as above. On the falling edge of ioctl_download:
    - counter == 0x3000 and no overflow → DONE.
    - otherwise → ERROR.
  - DONE: cpu_hold = 0 and load_done = 1, both asserted the cycle after the falling edge. A new matching download → LOAD, re-asserting cpu_hold in the same cycle as the state change.
  - ERROR: load_err = 1, cpu_hold stays 1. A new matching download → LOAD.
- Edge detection uses a registered copy of ioctl_download.
- ioctl_wr in the same cycle as the falling edge: the byte is written and counted before the size check.
- Download with a non-matching index: ignored in every state. The current state and outputs are unchanged.
- Duplicate addresses: each is written and counted. The resulting count ≠ 0x3000 leads to ERROR. This is intended, to catch malformed MRA files.
- Reset mid-download: all outputs return to reset values and state = IDLE. Any remaining strobes of that download are ignored until the next rising edge.

Decomposition:
- Shared package: ROM_INDEX value, region bases PROG_BASE = 0x0000, GFX_BASE = 0x2000, expected image size 0x3000, state enum {IDLE, LOAD, DONE, ERROR}.
- One natural sub-module, rom_region_decode: combinational address → {prog_sel, gfx_sel, overflow, local_addr}.
- FSM, counter and checksum stay in rom_loader.

Test Plan:
- Full load: bytes 0x00..0x2FFF, each value = addr[7:0], index 0 → 8192 prog_we and 4096 gfx_we pulses, each 1 cycle after its strobe. prog_sum = 0x00. load_done = 1 and cpu_hold = 0 one cycle after the falling edge.
- Short load: 0x2FFF bytes → ERROR. load_err = 1, cpu_hold = 1, load_done = 0.
- Overflow: full image plus one byte at 0x3000 → no write for the extra byte, ERROR.
- Wrong index: download with index 1 after a good load → no we pulses. load_done stays 1, cpu_hold stays 0.
- Reset at byte 0x1000 → cpu_hold = 1, state IDLE, prog_sum = 0. Remaining strobes produce no we. A following full download reaches DONE.
- Last byte's ioctl_wr coincident with the download falling edge → byte 0x2FFF is written to gfx_addr 0xFFF, gfx_we pulses, and the block reaches DONE.
